// File: rtl/coin_return_arb.sv
// Two-port coin-return arbiter: round-robin grant, then greedy 25/10/5 change
// payout as timed ejector pulses separated by a quiet gap.
module coin_return_arb #(
   parameter int unsigned PULSE_CYC = 8,
   parameter int unsigned GAP_CYC   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [8:0] amt0,
   input  logic [8:0] amt1,
   input  logic       empty_5,
   input  logic       empty_10,
   input  logic       empty_25,
   output logic [1:0] gnt,
   output logic       busy,
   output logic [1:0] done,
   output logic [8:0] residual,
   output logic       return_5,
   output logic       return_10,
   output logic       return_25
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PICK,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);

   state_t     state_q, state_d;
   logic [1:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;
   logic [1:0] done_q, done_d;
   logic [8:0] residual_q, residual_d;
   logic [8:0] bal_q, bal_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] ret_q, ret_d;    // {return_25, return_10, return_5}
   logic       last_q, last_d;  // port served most recently
   logic       pick1;

   // Port 1 wins when it is alone, or when both ask and port 0 was served last.
   assign pick1 = req[1] & (~req[0] | ~last_q);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      done_d     = 2'b00;
      residual_d = residual_q;
      bal_d      = bal_q;
      cnt_d      = cnt_q;
      ret_d      = ret_q;
      last_d     = last_q;
      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               state_d = S_PICK;
               gnt_d   = pick1 ? 2'b10 : 2'b01;
               bal_d   = pick1 ? amt1 : amt0;
            end
         end
         S_PICK: begin
            if (bal_q >= 9'd25 && !empty_25) begin
               ret_d   = 3'b100;
               bal_d   = bal_q - 9'd25;
               cnt_d   = PULSE_LOAD;
               state_d = S_PULSE;
            end else if (bal_q >= 9'd10 && !empty_10) begin
               ret_d   = 3'b010;
               bal_d   = bal_q - 9'd10;
               cnt_d   = PULSE_LOAD;
               state_d = S_PULSE;
            end else if (bal_q >= 9'd5 && !empty_5) begin
               ret_d   = 3'b001;
               bal_d   = bal_q - 9'd5;
               cnt_d   = PULSE_LOAD;
               state_d = S_PULSE;
            end else begin
               done_d     = gnt_q;
               residual_d = bal_q;
               state_d    = S_DONE;
            end
         end
         S_PULSE: begin
            if (cnt_q == 8'd0) begin
               ret_d   = 3'b000;
               cnt_d   = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_PICK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DONE: begin
            last_d  = gnt_q[1];
            gnt_d   = 2'b00;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
            ret_d   = 3'b000;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         gnt_q      <= 2'b00;
         busy_q     <= 1'b0;
         done_q     <= 2'b00;
         residual_q <= 9'd0;
         bal_q      <= 9'd0;
         cnt_q      <= 8'd0;
         ret_q      <= 3'b000;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         residual_q <= residual_d;
         bal_q      <= bal_d;
         cnt_q      <= cnt_d;
         ret_q      <= ret_d;
         last_q     <= last_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign residual  = residual_q;
   assign return_25 = ret_q[2];
   assign return_10 = ret_q[1];
   assign return_5  = ret_q[0];

endmodule

// File: doc/coin_return_arb.md
COIN_RETURN_ARB -- requirements
Module: coin_return_arb

Interface
REQ-001 Parameter: PULSE_CYC, default 8, cycles each coin-return pulse is held high (1..255).
REQ-002 Parameter: GAP_CYC, default 8, cycles all returns are held low after each pulse (1..255).
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: req  in  2  req[i] = requester i asks for change; held until done[i].
REQ-006 Port: amt0  in  9  change amount in cents for requester 0.
REQ-007 Port: amt1  in  9  change amount in cents for requester 1.
REQ-008 Port: empty_5 / empty_10 / empty_25  in  1 each  coin tube empty flags.
REQ-009 Port: gnt  out  2  one-hot grant; marks the requester being served.
REQ-010 Port: busy  out  1  high whenever the state is not IDLE.
REQ-011 Port: done  out  2  one-cycle pulse on done[i] when service of requester i ends.
REQ-012 Port: residual  out  9  unpaid balance of the last completed service.
REQ-013 Port: return_5 / return_10 / return_25  out  1 each  coin ejector pulses.

Function
REQ-014 States SHALL be IDLE, PICK, PULSE, GAP and DONE; all outputs SHALL be registered.
REQ-015 IDLE with any req high SHALL go to PICK next cycle, set gnt, and latch the winner's amount into a 9-bit balance.
REQ-016 Arbitration SHALL be round-robin: with both req high, grant the port not served last; the pointer updates in DONE.
REQ-017 A single req SHALL be granted regardless of the pointer.
REQ-018 Amounts SHALL be sampled only at grant; later amt or req changes SHALL NOT affect the service in progress.
REQ-019 PICK SHALL be greedy, with empty flags sampled in PICK only. Rules, in priority order:
  - balance>=25 and !empty_25: assert return_25 and subtract 25.
  - else balance>=10 and !empty_10: assert return_10 and subtract 10.
  - else balance>=5 and !empty_5: assert return_5 and subtract 5.
  - else go to DONE.
REQ-020 A coin selection SHALL enter PULSE and hold exactly one return_x high for exactly PULSE_CYC cycles.
REQ-021 GAP SHALL follow PULSE, hold all returns low for exactly GAP_CYC cycles, then go to PICK.
REQ-022 At most one return_x SHALL be high in any cycle.
REQ-023 Latency: req seen in IDLE at cycle N gives gnt at N+1 and the first return_x at N+2.
REQ-024 DONE SHALL last one cycle:
  - pulse done[i] for the granted port.
  - load residual with the balance.
  - clear gnt on the next cycle.
  - return to IDLE.
REQ-025 residual SHALL hold its value until the next DONE.
REQ-026 An amount of 0 SHALL go PICK -> DONE with no return pulse and residual 0.
REQ-027 Subtraction SHALL never underflow, because of the >= checks.
REQ-028 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.

Reset
REQ-029 reset high at a clock edge SHALL force, on the next cycle:
  - state IDLE; gnt, busy, done and all return_x = 0.
  - residual = 0, balance = 0, counters = 0.
  - round-robin pointer favouring port 0.
REQ-030 reset SHALL override any state, including mid-PULSE, and abort service without a done pulse.

Verification
REQ-031 req=01, amt0=40, no empties, PULSE/GAP=8 -> return_25 for 8 cycles, gap of 8, return_10 for 8, gap of 8, return_5 for 8, gap of 8, then done[0] pulse and residual=0; gnt[0] at N+1, return_25 at N+2.
REQ-032 After reset, req=11 held, amt0=5, amt1=10 -> port 0 served first (return_5), then port 1 (return_10); each done pulses once.
REQ-033 empty_25=1, amt0=30 -> three return_10 pulses and no return_25; residual=0.
REQ-034 empty_5=1, amt1=7 -> no return pulses, done[1], residual=7; amt0=0 -> done[0] with no pulses.
REQ-035 reset asserted during the 3rd cycle of a return_25 pulse -> all outputs 0 the next cycle, no done pulse, next req=11 granted to port 0.
